flags_unit: RTL

Parametrised status-flag unit for the jrb8 datapath, the successor of the single-register compare/flags block. It captures Z/O/C/S from a WIDTH-bit ALU result under a per-flag write mask. It supports chained zero detection for multi-word compares and a DEPTH-entry flag save stack for interrupt/call entry and return. It also evaluates a 4-bit branch condition code against the registered flags for the control unit.

---
 rtl/flags_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/flags_unit.sv
// Status-flag unit: Z/O/C/S capture under write mask, chained zero detect,
// flag save stack and branch-condition evaluation. Optional macro: FLAGS_STICKY_OV_EN.
module flags_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             overflow,
    input  logic             carry,
    input  logic             we,
    input  logic [3:0]       wmask,
    input  logic             chain,
    input  logic             push,
    input  logic             pop,
    input  logic             restore_we,
    input  logic [3:0]       restore_flags,
    input  logic [3:0]       cond,
    output logic             zflag,
    output logic             oflag,
    output logic             cflag,
    output logic             sflag,
    output logic             cond_true,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Flag vector layout is {S,C,O,Z}, matching wmask and restore_flags.
    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [DEPTH];

    logic          full, empty, push_ok, pop_ok;
    logic          z_new, o_new;
    logic [3:0]    upd;
    logic [IW-1:0] wr_idx, rd_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign wr_idx  = IW'(count_q);
    assign rd_idx  = IW'(count_q - CW'(1));

    always_comb begin
        z_new = (result == '0) & (~chain | flags_q[0]);
`ifdef FLAGS_STICKY_OV_EN
        o_new = flags_q[1] | overflow;
`else
        o_new = overflow;
`endif
        upd = {result[WIDTH-1], carry, o_new, z_new};
    end

    always_comb begin
        flags_d = flags_q;
        if (pop_ok)
            flags_d = stack_q[rd_idx];
        else if (restore_we)
            flags_d = restore_flags;
        else if (we)
            flags_d = (upd & wmask) | (flags_q & ~wmask);

        count_d = count_q;
        if (push_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok)
            count_d = count_q - CW'(1);

        // Simultaneous push/pop is treated as a conflict, not a swap.
        err_d = err_q | (push & pop) | (push & full) | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack contents carry no reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            stack_q[wr_idx] <= flags_q;
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = 1'b1;
            4'd1:  cond_true = flags_q[0];
            4'd2:  cond_true = ~flags_q[0];
            4'd3:  cond_true = flags_q[2];
            4'd4:  cond_true = ~flags_q[2];
            4'd5:  cond_true = flags_q[3];
            4'd6:  cond_true = ~flags_q[3];
            4'd7:  cond_true = flags_q[1];
            4'd8:  cond_true = ~flags_q[1];
            4'd9:  cond_true = flags_q[2] & ~flags_q[0];
            4'd10: cond_true = ~flags_q[2] | flags_q[0];
            4'd11: cond_true = (flags_q[3] == flags_q[1]);
            4'd12: cond_true = (flags_q[3] != flags_q[1]);
            4'd13: cond_true = ~flags_q[0] & (flags_q[3] == flags_q[1]);
            4'd14: cond_true = flags_q[0] | (flags_q[3] != flags_q[1]);
            default: cond_true = 1'b0;
        endcase
    end

    assign zflag       = flags_q[0];
    assign oflag       = flags_q[1];
    assign cflag       = flags_q[2];
    assign sflag       = flags_q[3];
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule
